pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the stall and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers three hazard classes:
  - load-use hazards: 1-cycle stall plus bubble;
  - EX-resolved redirects from branch/jal/jalr: flush plus bubble;
  - multi-cycle MUL/DIV ops in EX: start/done handshake that freezes the front end.
- Also keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32: width of the performance counters.
- MDU_MAX_CYC, 64: maximum number of MDU_WAIT cycles before a forced release (valid range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr
- ex_mdu_op  in  1  EX instruction is a multi-cycle MUL/DIV
- mdu_done  in  1  MDU result valid, 1-cycle pulse
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID
- idex_stall  out  1  hold ID/EX contents
- idex_bubble  out  1  load ID/EX with zeroed control (MemWrite, RegWrite, MemRead, branch/jump)
- exmem_bubble  out  1  load EX/MEM with zeroed control
- mdu_start  out  1  1-cycle MDU launch pulse
- busy  out  1  state is MDU_WAIT
- mdu_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  cycles with pc_stall=1
- flush_cnt  out  CNT_W  cycles with ifid_flush=1

Behaviour:
- Control outputs are combinational from state and inputs, for same-cycle effect. They are forced to 0 while rst=1.
- Counters, state, wait counter and mdu_timeout are registered. All reset to 0 / RUN.
- States: RUN, MDU_WAIT. The wait counter is 8 bits.
- Load-use hazard: lu = ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, evaluated in priority order:
  1. ex_mdu_op:
     - mdu_start=1; pc_stall=ifid_stall=idex_stall=exmem_bubble=1.
     - Next state MDU_WAIT, wait counter=1.
     - ex_redirect and lu are ignored this cycle.
     - mdu_done is ignored in RUN.
  2. ex_redirect:
     - ifid_flush=1, idex_bubble=1, no stalls.
     - lu in the same cycle is ignored; the ID instruction is squashed anyway.
  3. lu:
     - pc_stall=ifid_stall=idex_bubble=1.
     - Exactly one cycle; the load then leaves EX and forwarding covers the dependency.
  4. Otherwise all control outputs are 0.
- MDU_WAIT:
  - mdu_done=1: all controls 0 (release). The EX result passes into EX/MEM at the next edge; next state RUN.
  - Else if wait counter==MDU_MAX_CYC: release exactly as for done; set mdu_timeout at the next edge; next state RUN.
  - Else: pc_stall=ifid_stall=idex_stall=exmem_bubble=1; wait counter+1.
  - ex_redirect, lu and ex_mdu_op are ignored. ex_mdu_op remains high during the release cycle but must not re-launch.
- mdu_start is high only in the RUN launch cycle, never in MDU_WAIT.
- Counters: +1 per cycle with the respective output high. They saturate at all-ones and never wrap.
- mdu_timeout is sticky until rst.
- rst mid-MDU_WAIT: immediate return to RUN, outputs 0, counters cleared. The MDU is not notified.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MDU_WAIT};
  - default CNT_W;
  - wait counter width 8.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output q). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset: assert rst with random inputs -> every output 0, stall_cnt=flush_cnt=0, busy=0; deassert -> state RUN.
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_stall=ifid_stall=idex_bubble=1 that cycle only, stall_cnt=1. Repeat with ex_rd=0 or id_use_rs1=0 -> no stall.
- Redirect vs load-use: ex_redirect=1 with the load-use condition true -> ifid_flush=idex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
- MDU handshake:
  - Stimulus: ex_mdu_op=1 from cycle 0, mdu_done pulse at cycle 4.
  - mdu_start=1 at cycle 0 only; stalls and exmem_bubble high cycles 0-3; all 0 at cycle 4; busy cycles 1-4; stall_cnt=4; no second mdu_start at cycle 4.
- Timeout:
  - Stimulus: MDU_MAX_CYC=8, no mdu_done.
  - Stalls cycles 0-7; release at cycle 8; mdu_timeout=1 from cycle 9 and held until rst.
- Reset mid-wait: rst asserted at cycle 3 of an MDU op -> busy=0 and stalls 0 immediately; after deassert ex_mdu_op=1 -> fresh mdu_start pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
// State encoding and counter widths used by the control block.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_e;

    localparam int CNT_W_DEF = 32;
    localparam int WAIT_W    = 8;

    typedef logic [WAIT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from ID/EX and stall/flush controls back to the pipeline.
// master = the hazard controller, slave = the pipeline datapath.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);

    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_redirect;
    logic             ex_mdu_op;
    logic             mdu_done;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             mdu_start;
    logic             busy;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_memread, ex_redirect, ex_mdu_op,
        input  mdu_done,
        output pc_stall, ifid_stall, ifid_flush,
        output idex_stall, idex_bubble, exmem_bubble,
        output mdu_start, busy, mdu_timeout,
        output stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_memread, ex_redirect, ex_mdu_op,
        output mdu_done,
        input  pc_stall, ifid_stall, ifid_flush,
        input  idex_stall, idex_bubble, exmem_bubble,
        input  mdu_start, busy, mdu_timeout,
        input  stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use, EX redirects and multi-cycle MDU ops.
// Controls are combinational for same-cycle effect; state is registered.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MDU_MAX_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.master  hz
);

    localparam wait_cnt_t MAX_C = wait_cnt_t'(MDU_MAX_CYC);

    state_e    state_q, state_d;
    wait_cnt_t wcnt_q, wcnt_d;
    logic      tmo_q, tmo_d;

    logic hit1, hit2, lu;
    logic do_launch, do_redir, do_lu;
    logic at_max;

    logic pc_stall, ifid_stall, ifid_flush;
    logic idex_stall, idex_bubble, exmem_bubble;
    logic mdu_start;

    logic pc_stall_o, ifid_flush_o;

    assign hit1 = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    assign hit2 = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
    assign lu   = hz.ex_memread && (hz.ex_rd != 5'd0) && (hit1 || hit2);

    // Mutually exclusive RUN actions, highest priority first.
    assign do_launch = hz.ex_mdu_op;
    assign do_redir  = hz.ex_redirect && !hz.ex_mdu_op;
    assign do_lu     = lu && !hz.ex_redirect && !hz.ex_mdu_op;
    assign at_max    = (wcnt_q == MAX_C);

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        tmo_d        = tmo_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mdu_start    = 1'b0;
        unique case (state_q)
            RUN: begin
                unique case (1'b1)
                    do_launch: begin
                        mdu_start    = 1'b1;
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_stall   = 1'b1;
                        exmem_bubble = 1'b1;
                        state_d      = MDU_WAIT;
                        wcnt_d       = wait_cnt_t'(1);
                    end
                    do_redir: begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                    do_lu: begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                    default: ;
                endcase
            end
            MDU_WAIT: begin
                if (hz.mdu_done || at_max) begin
                    // Release cycle: EX result moves into EX/MEM at the next edge.
                    state_d = RUN;
                    if (!hz.mdu_done) begin
                        tmo_d = 1'b1;
                    end
                end else begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    wcnt_d       = wcnt_q + wait_cnt_t'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign pc_stall_o   = pc_stall && !rst;
    assign ifid_flush_o = ifid_flush && !rst;

    assign hz.pc_stall     = pc_stall_o;
    assign hz.ifid_stall   = ifid_stall && !rst;
    assign hz.ifid_flush   = ifid_flush_o;
    assign hz.idex_stall   = idex_stall && !rst;
    assign hz.idex_bubble  = idex_bubble && !rst;
    assign hz.exmem_bubble = exmem_bubble && !rst;
    assign hz.mdu_start    = mdu_start && !rst;
    assign hz.busy         = (state_q == MDU_WAIT) && !rst;
    assign hz.mdu_timeout  = tmo_q && !rst;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_stall_o),
        .q   (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush_o),
        .q   (hz.flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl with a queue of expected control words.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       r;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       rdr;
        logic       mdu;
        logic       dn;
    } stim_t;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
    //  exmem_bubble, mdu_start, busy, mdu_timeout}
    localparam logic [8:0] C_IDLE = 9'b000_000_000;
    localparam logic [8:0] C_LU   = 9'b110_010_000;
    localparam logic [8:0] C_RDR  = 9'b001_010_000;
    localparam logic [8:0] C_LNCH = 9'b110_101_100;
    localparam logic [8:0] C_WAIT = 9'b110_101_010;
    localparam logic [8:0] C_REL  = 9'b000_000_010;
    localparam logic [8:0] C_TMO  = 9'b000_000_001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] ctrl;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

    pipe_hazard_ctrl #(
        .CNT_W       (32),
        .MDU_MAX_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.master)
    );

    always #5 clk = ~clk;

    assign ctrl = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush,
                   hz.idex_stall, hz.idex_bubble, hz.exmem_bubble,
                   hz.mdu_start, hz.busy, hz.mdu_timeout};

    function automatic stim_t mk(logic r, logic mr, logic [4:0] rd,
                                 logic [4:0] rs1, logic [4:0] rs2,
                                 logic u1, logic u2, logic rdr,
                                 logic mdu, logic dn);
        stim_t s;
        s = '{r:r, mr:mr, rd:rd, rs1:rs1, rs2:rs2,
              u1:u1, u2:u2, rdr:rdr, mdu:mdu, dn:dn};
        return s;
    endfunction

    task automatic put(input stim_t s);
        rst            = s.r;
        hz.ex_memread  = s.mr;
        hz.ex_rd       = s.rd;
        hz.id_rs1      = s.rs1;
        hz.id_rs2      = s.rs2;
        hz.id_use_rs1  = s.u1;
        hz.id_use_rs2  = s.u2;
        hz.ex_redirect = s.rdr;
        hz.ex_mdu_op   = s.mdu;
        hz.mdu_done    = s.dn;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        stim_t s;
        for (int i = 0; i < 5; i++) begin
            s = stim_t'({$urandom, $urandom});
            s.r = 1'b1;
            put(s);
            exp_q.push_back(C_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL reset[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            checks++;
            if (hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0) begin
                errors++;
                $display("FAIL reset_cnt[%0d] stall=%0d flush=%0d exp 0/0",
                         i, hz.stall_cnt, hz.flush_cnt);
            end
            @(posedge clk);
            #1;
        end
        put(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(C_IDLE);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ctrl !== e) begin
            errors++;
            $display("FAIL reset_release ctrl=%b exp=%b", ctrl, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [8:0] e;
        st.push_back(mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0)); exp_q.push_back(C_LU);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        st.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        st.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        st.push_back(mk(0, 1, 7, 1, 7, 0, 1, 0, 0, 0)); exp_q.push_back(C_LU);
        st.push_back(mk(0, 0, 7, 7, 7, 1, 1, 0, 0, 0)); exp_q.push_back(C_IDLE);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); exp_q.push_back(C_IDLE);
        foreach (st[i]) begin
            put(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL load_use[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hz.stall_cnt !== 32'd2 || hz.flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL load_use_cnt stall=%0d flush=%0d exp 2/0",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_redirect();
        stim_t st[$];
        logic [8:0] e;
        st.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 0)); exp_q.push_back(C_RDR);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        foreach (st[i]) begin
            put(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL redirect[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hz.stall_cnt !== 32'd2 || hz.flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL redirect_cnt stall=%0d flush=%0d exp 2/1",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_mdu();
        stim_t st[$];
        logic [8:0] e;
        // Launch wins over a simultaneous redirect and load-use.
        st.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 1, 0)); exp_q.push_back(C_LNCH);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); exp_q.push_back(C_WAIT);
        st.push_back(mk(0, 1, 5, 5, 0, 1, 0, 0, 1, 0)); exp_q.push_back(C_WAIT);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_WAIT);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); exp_q.push_back(C_REL);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        foreach (st[i]) begin
            put(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL mdu[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hz.stall_cnt !== 32'd6 || hz.flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL mdu_cnt stall=%0d flush=%0d exp 6/1",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        logic [8:0] e;
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_LNCH);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); exp_q.push_back(C_REL);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_LNCH);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); exp_q.push_back(C_REL);
        st.push_back(mk(0, 1, 3, 3, 0, 1, 0, 0, 0, 0)); exp_q.push_back(C_LU);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        foreach (st[i]) begin
            put(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL b2b[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hz.stall_cnt !== 32'd9 || hz.flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL b2b_cnt stall=%0d flush=%0d exp 9/1",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_timeout();
        stim_t st[$];
        logic [8:0] e;
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_LNCH);
        for (int k = 1; k < 8; k++) begin
            st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            exp_q.push_back(C_WAIT);
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_REL);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_TMO);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); exp_q.push_back(C_RDR | C_TMO);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); exp_q.push_back(C_TMO);
        foreach (st[i]) begin
            put(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL timeout[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hz.stall_cnt !== 32'd17 || hz.flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL timeout_cnt stall=%0d flush=%0d exp 17/2",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t st[$];
        logic [8:0] e;
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_LNCH | C_TMO);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_WAIT | C_TMO);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_WAIT | C_TMO);
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_IDLE);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(C_LNCH);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); exp_q.push_back(C_REL);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(C_IDLE);
        foreach (st[i]) begin
            put(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e) begin
                errors++;
                $display("FAIL rst_mid[%0d] ctrl=%b exp=%b", i, ctrl, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hz.stall_cnt !== 32'd1 || hz.flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_cnt stall=%0d flush=%0d exp 1/0",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        put(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_redirect();
        test_mdu();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left size=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
